// File: rtl/step_sched.sv
// Round-robin scheduler that shares one 2-bit step counter among NREQ requesters.
// Each granted job drives step for its requested length, then gets a one-cycle done pulse.
module step_sched #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned CNTW = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CNTW-1:0] req_steps,
   output logic                 step,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [1:0]           pos
);

   localparam int unsigned IW = $clog2(NREQ);

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StArb  = 2'b01,
      StRun  = 2'b10,
      StDone = 2'b11
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CNTW-1:0] rem_q, rem_d;
   logic [1:0]      pos_q, pos_d;

   logic            found;
   logic [IW-1:0]   win;
   logic [IW-1:0]   cand;
   logic [CNTW-1:0] win_steps;
   logic [NREQ-1:0] idx_oh;

   // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IW'((32'(ptr_q) + k) % NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      win_steps = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win == IW'(i)) begin
            win_steps = req_steps[i*CNTW +: CNTW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      pos_d   = pos_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StArb;
            end
         end
         StArb: begin
            if (!found) begin
               state_d = StIdle;
            end else begin
               idx_d   = win;
               rem_d   = win_steps;
               state_d = (win_steps == '0) ? StDone : StRun;
            end
         end
         StRun: begin
            rem_d = rem_q - 1'b1;
            pos_d = pos_q + 2'd1;
            if (rem_q == CNTW'(1)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            ptr_d   = idx_q;
            state_d = (|req) ? StArb : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         ptr_q   <= IW'(NREQ - 1);
         rem_q   <= '0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         pos_q   <= pos_d;
      end
   end

   // Moore outputs: decoded purely from registered state and owner index.
   always_comb begin
      idx_oh        = '0;
      idx_oh[idx_q] = 1'b1;
   end

   assign step = (state_q == StRun);
   assign gnt  = (state_q != StIdle) ? idx_oh : '0;
   assign done = (state_q == StDone) ? idx_oh : '0;
   assign busy = (state_q != StIdle);
   assign pos  = pos_q;

endmodule

// File: tb/tb_step_sched.sv
// Directed self-checking bench for step_sched (NREQ=4, CNTW=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_step_sched;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_steps;
   logic        step;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [1:0]  pos;

   int total;
   int bad;

   step_sched #(
      .NREQ(4),
      .CNTW(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_steps (req_steps),
      .step      (step),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .pos       (pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      req_steps = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if ({step, gnt, done, busy, pos} !== 12'h000) begin
            bad++;
            $display("FAIL reset cyc%0d: got step=%b gnt=%b done=%b busy=%b pos=%0d want all 0",
                     c, step, gnt, done, busy, pos);
         end
      end
   endtask

   task automatic test_single();
      int nstep;
      nstep = 0;
      req_steps = 16'h0003;
      req = 4'b0001;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (step) nstep++;
         total++;
         if (step !== (c >= 2 && c <= 4)) begin
            bad++;
            $display("FAIL single step cyc%0d: got %b want %b", c, step, (c >= 2 && c <= 4));
         end
         if (c >= 2 && c <= 5) begin
            total++;
            if (gnt !== 4'b0001) begin
               bad++;
               $display("FAIL single gnt cyc%0d: got %b want 0001", c, gnt);
            end
         end
         total++;
         if (done !== ((c == 5) ? 4'b0001 : 4'b0000)) begin
            bad++;
            $display("FAIL single done cyc%0d: got %b", c, done);
         end
         if (c == 5) begin
            total++;
            if (pos !== 2'd3) begin
               bad++;
               $display("FAIL single pos: got %0d want 3", pos);
            end
            req = '0;
         end
         if (c == 6) begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL single idle busy: got %b want 0", busy);
            end
         end
      end
      total++;
      if (nstep != 3) begin
         bad++;
         $display("FAIL single nstep: got %0d want 3", nstep);
      end
   endtask

   task automatic test_round_robin();
      logic [13:0] exp_step;
      logic [3:0]  exp_done [14];
      logic [3:0]  exp_gnt  [14];
      logic [1:0]  exp_pos  [14];
      exp_step = 14'b0_1100_1001_1001_0; // bit c-1 = cycle c
      exp_step = 14'b01100100110010;
      for (int i = 0; i < 14; i++) begin
         exp_done[i] = 4'b0000;
         exp_gnt[i]  = 4'b0000;
         exp_pos[i]  = 2'd0;
      end
      // cycles: 2 run j0; 5,6 run j2; 9 run j0; 12,13 run j2
      exp_gnt[1] = 4'b0001; exp_gnt[4] = 4'b0100; exp_gnt[5] = 4'b0100;
      exp_gnt[8] = 4'b0001; exp_gnt[11] = 4'b0100; exp_gnt[12] = 4'b0100;
      exp_done[2] = 4'b0001; exp_done[6] = 4'b0100;
      exp_done[9] = 4'b0001; exp_done[13] = 4'b0100;
      exp_pos[2] = 2'd1; exp_pos[6] = 2'd3; exp_pos[9] = 2'd0; exp_pos[13] = 2'd2;
      do_reset();
      req_steps = 16'h0201;
      req = 4'b0101;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         total++;
         if (step !== exp_step[c-1]) begin
            bad++;
            $display("FAIL rr step cyc%0d: got %b want %b", c, step, exp_step[c-1]);
         end
         total++;
         if (done !== exp_done[c-1]) begin
            bad++;
            $display("FAIL rr done cyc%0d: got %b want %b", c, done, exp_done[c-1]);
         end
         if (exp_step[c-1]) begin
            total++;
            if (gnt !== exp_gnt[c-1]) begin
               bad++;
               $display("FAIL rr gnt cyc%0d: got %b want %b", c, gnt, exp_gnt[c-1]);
            end
         end
         if (exp_done[c-1] != 4'b0000) begin
            total++;
            if (pos !== exp_pos[c-1]) begin
               bad++;
               $display("FAIL rr pos cyc%0d: got %0d want %0d", c, pos, exp_pos[c-1]);
            end
         end
         if (c == 14) req = '0;
      end
   endtask

   task automatic test_zero_len();
      req_steps = 16'h0000;
      req = 4'b1000;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         total++;
         if (step !== 1'b0) begin
            bad++;
            $display("FAIL zero step cyc%0d: got %b want 0", c, step);
         end
         total++;
         if (done !== ((c == 2) ? 4'b1000 : 4'b0000)) begin
            bad++;
            $display("FAIL zero done cyc%0d: got %b", c, done);
         end
         total++;
         if (pos !== 2'd2) begin
            bad++;
            $display("FAIL zero pos cyc%0d: got %0d want 2", c, pos);
         end
         if (c == 2) req = '0;
      end
   endtask

   task automatic test_abort();
      do_reset();
      req_steps = 16'h0005;
      req = 4'b0001;
      repeat (3) @(negedge clk);
      total++;
      if (step !== 1'b1 || pos !== 2'd1) begin
         bad++;
         $display("FAIL abort pre: got step=%b pos=%0d want step=1 pos=1", step, pos);
      end
      rst = 1'b1;
      req = '0;
      #1;
      total++;
      if ({step, gnt, done, busy, pos} !== 12'h000) begin
         bad++;
         $display("FAIL abort async: got step=%b gnt=%b done=%b busy=%b pos=%0d want all 0",
                  step, gnt, done, busy, pos);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         total++;
         if (done !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort quiet cyc%0d: got done=%b busy=%b want 0", c, done, busy);
         end
      end
      req_steps = 16'h0011;
      req = 4'b0011;
      repeat (2) @(negedge clk);
      total++;
      if (gnt !== 4'b0001 || step !== 1'b1) begin
         bad++;
         $display("FAIL abort first gnt: got gnt=%b step=%b want 0001/1", gnt, step);
      end
      @(negedge clk);
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_wrap_drop();
      int nstep;
      bit seen_done;
      nstep = 0;
      seen_done = 0;
      do_reset();
      req_steps = 16'h0060;
      req = 4'b0010;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (step) nstep++;
         if (done == 4'b0010) begin
            seen_done = 1;
            total++;
            if (c != 8 || pos !== 2'd2) begin
               bad++;
               $display("FAIL wrap done: got cyc%0d pos=%0d want cyc8 pos=2", c, pos);
            end
         end
         if (c == 3) begin
            req = '0;
            req_steps = 16'h0010;
         end
      end
      total++;
      if (nstep != 6 || !seen_done) begin
         bad++;
         $display("FAIL wrap steps: got %0d done_seen=%0d want 6 1", nstep, seen_done);
      end
      total++;
      if (pos !== 2'd2 || busy !== 1'b0) begin
         bad++;
         $display("FAIL wrap final: got pos=%0d busy=%b want 2 0", pos, busy);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      req = '0;
      req_steps = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_zero_len();
      test_abort();
      test_wrap_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
